// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit width, blank code,
// and the active-low hex segment patterns, ordered {g,f,e,d,c,b,a}.
// No ports. Imported by seg7_decoder and seven_seg_scan_driver.
package seg7_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index = hex digit value. A bit value of 0 lights that segment.
    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'h40, // 0
        7'h79, // 1
        7'h24, // 2
        7'h30, // 3
        7'h19, // 4
        7'h12, // 5
        7'h02, // 6
        7'h78, // 7
        7'h00, // 8
        7'h10, // 9
        7'h08, // A
        7'h03, // b
        7'h46, // C
        7'h21, // d
        7'h06, // E
        7'h0E  // F
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex digit to active-low seven-segment pattern.
// Latency: none (pure lookup). Backpressure: none.
// Ports: value (4-bit hex digit) -> seg_n (7-bit {g,f,e,d,c,b,a}, active-low).
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    output logic [6:0]         seg_n
);

    assign seg_n = SEG_PATTERN[value];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: scans DIGITS digits, each held REFRESH_DIV clocks.
// Latency: one clock from the internal digit index to the registered seg_n/dp_n/an_n.
// Backpressure: none; enable low freezes the scan position and blanks all outputs.
// Ports: clk, reset_n (async, active-low), enable, digit_values[4*DIGITS], dp_in[DIGITS]
//        -> seg_n[7], dp_n, an_n[DIGITS] (all active-low, registered), frame_start (pulse).
// Optional macro LEADING_ZERO_BLANK_EN: blanks digits above the top nonzero digit (digit 0 always shown).
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int PRE_WIDTH   = 17
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [DIGIT_W*DIGITS-1:0] digit_values,
    input  logic [DIGITS-1:0]         dp_in,
    output logic [6:0]                seg_n,
    output logic                      dp_n,
    output logic [DIGITS-1:0]         an_n,
    output logic                      frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRE_WIDTH-1:0]        pre;
    logic [IDX_W-1:0]            idx;
    logic [DIGIT_W*DIGITS-1:0]   shadow;
    logic [DIGITS-1:0]           shadow_dp;
    logic                        load_pending;
    // Set whenever a new frame's data has been captured; consumed by the first
    // enabled output update so frame_start coincides with digit 0 appearing.
    logic                        fs_pending;

    logic                        tick;
    logic                        wrap;
    logic                        active;
    logic [DIGITS-1:0]           keep;
    logic [DIGITS-1:0]           sel;
    logic [DIGIT_W-1:0]          cur_val;
    logic                        cur_dp;
    logic                        cur_keep;
    logic [6:0]                  cur_seg_n;

    // The scan stays parked at pre=0/idx=0 until the first capture has happened,
    // so digit 0 of the freshly loaded frame gets its full REFRESH_DIV slot.
    assign active = enable && !load_pending;
    assign tick   = active && (pre == PRE_LAST);
    assign wrap   = tick && (idx == IDX_LAST);

`ifdef LEADING_ZERO_BLANK_EN
    // Built from the shadow copy, so the mask cannot change within a frame.
    logic nz_seen;
    always_comb begin
        nz_seen = 1'b0;
        keep    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (shadow[i*DIGIT_W +: DIGIT_W] != '0) begin
                nz_seen = 1'b1;
            end
            keep[i] = nz_seen || (i == 0);
        end
    end
`else
    assign keep = '1;
`endif

    // Select the currently scanned digit out of the shadow registers.
    always_comb begin
        cur_val  = '0;
        cur_dp   = 1'b0;
        cur_keep = 1'b0;
        sel      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_val  = shadow[i*DIGIT_W +: DIGIT_W];
                cur_dp   = shadow_dp[i];
                cur_keep = keep[i];
                sel[i]   = 1'b1;
            end
        end
    end

    seg7_decoder u_decoder (
        .value (cur_val),
        .seg_n (cur_seg_n)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre          <= '0;
            idx          <= '0;
            shadow       <= '0;
            shadow_dp    <= '0;
            load_pending <= 1'b1;
            fs_pending   <= 1'b0;
            seg_n        <= SEG_BLANK;
            dp_n         <= 1'b1;
            an_n         <= '1;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            // Scan position and shadow capture.
            if (enable && load_pending) begin
                shadow       <= digit_values;
                shadow_dp    <= dp_in;
                load_pending <= 1'b0;
                fs_pending   <= 1'b1;
            end else if (active) begin
                if (tick) begin
                    pre <= '0;
                    if (wrap) begin
                        idx        <= '0;
                        shadow     <= digit_values;
                        shadow_dp  <= dp_in;
                        fs_pending <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end else begin
                    pre <= pre + 1'b1;
                end
            end

            // Output register, driven from the pre-update index.
            if (active && cur_keep) begin
                an_n  <= ~sel;
                seg_n <= cur_seg_n;
                dp_n  <= ~cur_dp;
            end else begin
                an_n  <= '1;
                seg_n <= SEG_BLANK;
                dp_n  <= 1'b1;
            end

            // fs_pending is only set at wrap/load edges, where this branch cannot
            // also fire (idx is nonzero at wrap, load_pending blocks the load edge).
            if (active && fs_pending) begin
                frame_start <= 1'b1;
                fs_pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver with DIGITS=4, REFRESH_DIV=4.
// Outputs are sampled on the falling clock edge; inputs also change there.
// Observed vector is {an_n, seg_n, dp_n, frame_start}.
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] digit_values = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [12:0] BLANK = {4'hF, 7'h7F, 1'b1, 1'b0};

    logic [12:0] obs;
    assign obs = {an_n, seg_n, dp_n, frame_start};

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .DIGITS      (4),
        .REFRESH_DIV (4),
        .PRE_WIDTH   (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .digit_values (digit_values),
        .dp_in        (dp_in),
        .seg_n        (seg_n),
        .dp_n         (dp_n),
        .an_n         (an_n),
        .frame_start  (frame_start)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected output vector while digit d of word w is lit.
    function automatic logic [12:0] lit(input int d, input logic [15:0] w,
                                        input logic [3:0] dp, input logic fs);
        logic [3:0] an;
        an    = 4'hF;
        an[d] = 1'b0;
        return {an, seg_of(w[d*4 +: 4]), ~dp[d], fs};
    endfunction

    // Reset, release on a falling edge, then step past the capture edge.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        enable       = 1'b1;
        digit_values = 16'h1234;
        dp_in        = 4'b0000;
        reset_n      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (obs !== BLANK)
            $display("FAIL reset_state: got %h expected %h", obs, BLANK);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== BLANK)
            $display("FAIL load_cycle: got %h expected %h", obs, BLANK);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            exp = lit((c / 4) % 4, 16'h1234, 4'b0000, (c % 16) == 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL scan_1234 cycle %0d: got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_value_change();
        logic [12:0] exp;
        digit_values = 16'h1234;
        dp_in        = 4'b0000;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            exp = lit((c / 4) % 4, (c < 16) ? 16'h1234 : 16'h5678, 4'b0000, (c % 16) == 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL value_change cycle %0d: got %h expected %h", c, obs, exp);
            end
            if (c == 8) digit_values = 16'h5678;
        end
    endtask

    task automatic test_enable_pause();
        logic [12:0] exp;
        digit_values = 16'h1234;
        dp_in        = 4'b0000;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp = lit(c / 4, 16'h1234, 4'b0000, c == 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pause_pre cycle %0d: got %h expected %h", c, obs, exp);
            end
        end
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== BLANK) begin
                miscompares++;
                $display("FAIL pause_blank cycle %0d: got %h expected %h", k, obs, BLANK);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = lit((k < 2) ? 1 : 2, 16'h1234, 4'b0000, 1'b0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pause_resume cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_dp();
        logic [12:0] exp;
        digit_values = 16'h0A0F;
        dp_in        = 4'b0100;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp = lit(c / 4, 16'h0A0F, 4'b0100, c == 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL dp_0A0F cycle %0d: got %h expected %h", c, obs, exp);
            end
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_leading_zero();
        logic [12:0] exp;
        dp_in        = 4'b1111;
        digit_values = 16'h0030;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
            exp = ((c / 4) < 2) ? lit(c / 4, 16'h0030, 4'b1111, c == 0) : BLANK;
`else
            exp = lit(c / 4, 16'h0030, 4'b1111, c == 0);
`endif
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL lz_0030 cycle %0d: got %h expected %h", c, obs, exp);
            end
        end
        dp_in        = 4'b0000;
        digit_values = 16'h0000;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
            exp = ((c / 4) == 0) ? lit(0, 16'h0000, 4'b0000, c == 0) : BLANK;
`else
            exp = lit(c / 4, 16'h0000, 4'b0000, c == 0);
`endif
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL lz_0000 cycle %0d: got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_reset_pulse();
        logic [12:0] exp;
        digit_values = 16'h1234;
        dp_in        = 4'b0000;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            exp = lit(c / 4, 16'h1234, 4'b0000, c == 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pulse_pre cycle %0d: got %h expected %h", c, obs, exp);
            end
        end
        // Short low pulse entirely between clock edges.
        #1 reset_n = 1'b0;
        digit_values = 16'h00A9;
        #1;
        vectors++;
        if (obs !== BLANK) begin
            miscompares++;
            $display("FAIL pulse_async: got %h expected %h", obs, BLANK);
        end
        #1 reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== BLANK) begin
            miscompares++;
            $display("FAIL pulse_load: got %h expected %h", obs, BLANK);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp = lit(c / 4, 16'h00A9, 4'b0000, c == 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pulse_restart cycle %0d: got %h expected %h", c, obs, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_value_change();
        test_enable_pause();
        test_dp();
        test_leading_zero();
        test_reset_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
